// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle imem requests and queues
// {instr, pc} pairs in a DEPTH-entry FIFO for decode. Define FETCH_BYPASS_EN for the empty-FIFO bypass.

module riscv_fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic          fifo_pop,
  input logic [CW-1:0] count
);
  // The credit rule must keep every push away from a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && !fifo_pop) |-> (count < CW'(DEPTH)))
    else $error("fetch queue push into full FIFO");

  // Occupancy can never exceed the number of entries.
  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH))
    else $error("fetch queue count out of range");
endmodule

module riscv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = CW + 1;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];

  logic            fifo_empty_s;
  logic            bypass_s;
  logic            pop_s;
  logic            fifo_pop_s;
  logic            push_s;
  logic [NW-1:0]   need_s;
  logic            credit_s;

  // Decode-side view, pop/push qualification and the fetch credit check.
  always_comb begin
    fifo_empty_s = (count_q == CW'(0));
`ifdef FETCH_BYPASS_EN
    bypass_s     = fifo_empty_s && inflight_q;
`else
    bypass_s     = 1'b0;
`endif
    if (bypass_s) begin
      out_valid = 1'b1;
      out_instr = imem_rdata;
      out_pc    = inflight_pc_q;
    end else if (!fifo_empty_s) begin
      out_valid = 1'b1;
      out_instr = fifo_instr_q[rd_ptr_q];
      out_pc    = fifo_pc_q[rd_ptr_q];
    end else begin
      out_valid = 1'b0;
      out_instr = 32'h0000_0000;
      out_pc    = {XLEN{1'b0}};
    end
    pop_s      = out_valid && out_ready;
    fifo_pop_s = pop_s && !fifo_empty_s;
    // A bypassed response that decode takes never enters the FIFO.
    push_s     = inflight_q && !redirect && !(bypass_s && out_ready);
    need_s     = NW'(count_q) + NW'(inflight_q) - NW'(pop_s);
    credit_s   = (need_s < NW'(DEPTH));
    imem_req   = reset && !redirect && credit_s;
    imem_addr  = fetch_pc_q;
    occupancy  = count_q;
  end

  // Next-state for fetch PC, in-flight tracking and FIFO bookkeeping; redirect wins.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      inflight_d = 1'b0;
      rd_ptr_d   = PW'(0);
      wr_ptr_d   = PW'(0);
      count_d    = CW'(0);
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + PC_STEP;
        inflight_pc_d = fetch_pc_q;
      end else begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (fifo_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(fifo_pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {XLEN{1'b0}};
      rd_ptr_q      <= PW'(0);
      wr_ptr_q      <= PW'(0);
      count_q       <= CW'(0);
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage, written at the tail on each accepted response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  riscv_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .fifo_pop (fifo_pop_s),
    .count    (count_q)
  );
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: a queue-based fetch model checked every cycle,
// plus literal expectations for latency, backpressure, redirect, PC wrap and mid-stream reset.
`timescale 1ns/1ps
module tb_riscv_fetch_queue;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP       = 1'b1;
  localparam int FIRST_LAT = 1;
  localparam int RD_LAT    = 2;
`else
  localparam bit BYP       = 1'b0;
  localparam int FIRST_LAT = 2;
  localparam int RD_LAT    = 3;
`endif

  logic        clk = 1'b0;
  logic        reset, redirect, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic [2:0]  occupancy;
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_rdata, d2_instr, d2_pc;
  logic [2:0]  d2_occ;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .occupancy(occupancy));

  riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC2)) dut2 (
    .clk(clk), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
    .imem_rdata(d2_rdata), .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .out_valid(d2_valid), .out_ready(1'b1), .out_instr(d2_instr),
    .out_pc(d2_pc), .occupancy(d2_occ));

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // 1-cycle synchronous instruction memories; garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;
    d2_rdata   <= d2_req   ? instr_of(d2_addr)   : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: fetch PC, one in-flight PC, and a queue of buffered PCs.
  logic [31:0] m_pc = RST_PC;
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [31:0] m_q[$];
  bit          m_pop, m_byp, m_req;

  task automatic check_model();
    bit ev;
    logic [31:0] epc;
    if (!reset) begin
      m_q.delete(); m_inf = 1'b0; m_pc = RST_PC;
      m_pop = 1'b0; m_byp = 1'b0; m_req = 1'b0;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_occ", {29'd0, occupancy}, 32'd0);
      return;
    end
    m_byp = BYP && m_inf && (m_q.size() == 0);
    ev    = (m_q.size() > 0) || m_byp;
    epc   = m_byp ? m_inf_pc : ((m_q.size() > 0) ? m_q[0] : 32'h0);
    m_pop = ev && out_ready;
    m_req = !redirect && ((m_q.size() + int'(m_inf) - int'(m_pop)) < DEPTH);
    chk("req", {31'd0, imem_req}, {31'd0, m_req});
    chk("addr", imem_addr, m_pc);
    chk("valid", {31'd0, out_valid}, {31'd0, ev});
    chk("occ", {29'd0, occupancy}, m_q.size());
    if (ev) begin
      chk("out_pc", out_pc, epc);
      chk("out_instr", out_instr, instr_of(epc));
    end
  endtask

  task automatic update_model();
    if (!reset) return;
    if (redirect) begin
      m_q.delete(); m_inf = 1'b0; m_pc = redirect_pc & 32'hFFFF_FFFC;
      return;
    end
    if (m_pop && !m_byp) void'(m_q.pop_front());
    if (m_inf && !(m_byp && m_pop)) m_q.push_back(m_inf_pc);
    m_inf = m_req;
    m_inf_pc = m_pc;
    if (m_req) m_pc = m_pc + 32'd4;
  endtask

  logic [31:0] deliv[$];
  int          dcyc[$];
  logic [31:0] deliv2[$];
  int          pcyc = 0;
  int          n_req = 0;
  bit          rec2 = 1'b0;

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic mark();
    deliv.delete(); dcyc.delete(); pcyc = 0; n_req = 0;
  endtask

  // One cycle: drive at the falling edge, check 1 ns later, advance the model for the rising edge.
  task automatic cyc(input logic rst, input logic rdr, input logic [31:0] rpc, input logic rdy);
    reset = rst; redirect = rdr; redirect_pc = rpc; out_ready = rdy;
    #1;
    check_model();
    if (imem_req) n_req++;
    if (out_valid && out_ready) begin
      deliv.push_back(out_pc);
      dcyc.push_back(pcyc);
    end
    if (rec2 && d2_valid) deliv2.push_back(d2_pc);
    pcyc++;
    update_model();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset release with decode always ready; second instance starts near the top of memory.
    mark(); rec2 = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    rec2 = 1'b0;
    chk("first_lat", at(dcyc, 0), FIRST_LAT);
    chk("thru_cnt", deliv.size(), 8 - FIRST_LAT);
    for (int i = 0; i < 3; i++) chk("seq_pc", at(deliv, i), 32'h4 * i);
    chk("wrap0", at(deliv2, 0), 32'hFFFF_FFF8);
    chk("wrap1", at(deliv2, 1), 32'hFFFF_FFFC);
    chk("wrap2", at(deliv2, 2), 32'h0000_0000);

    // Backpressure: decode stalled fills the FIFO then fetch stops.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    mark();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_reqs", n_req, 32'd4);
    chk("bp_occ", {29'd0, occupancy}, 32'd4);
    chk("bp_req_off", {31'd0, imem_req}, 32'd0);
    mark();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) chk("bp_drain", at(deliv, i), 32'h4 * i);

    // Redirect with 3 queued and one response in flight.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("pre_rd_occ", {29'd0, occupancy}, 32'd3);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    chk("rd_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_occ", {29'd0, occupancy}, 32'd0);
    chk("rd_addr", imem_addr, 32'h0000_0100);
    mark();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rd_lat", at(dcyc, 0), RD_LAT - 1);
    chk("rd_first", at(deliv, 0), 32'h0000_0100);
    chk("rd_second", at(deliv, 1), 32'h0000_0104);

    // Misaligned redirect target truncates to the word.
    cyc(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    chk("mis_addr", imem_addr, 32'h0000_0100);
    mark();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mis_lat", at(dcyc, 0), RD_LAT - 1);
    chk("mis_first", at(deliv, 0), 32'h0000_0100);

    // Mid-stream reset with a request outstanding.
    chk("pre_rst_req", {31'd0, n_req > 0}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_instr", out_instr, 32'd0);
    chk("mid_pc", out_pc, 32'd0);
    chk("mid_occ", {29'd0, occupancy}, 32'd0);
    chk("mid_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    mark();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("post_lat", at(dcyc, 0), FIRST_LAT);
    chk("post_first", at(deliv, 0), RST_PC);
    chk("post_second", at(deliv, 1), 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
